decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/decode_pkg.sv | 68 ++++++
 rtl/register_file.sv | 66 ++++++
 rtl/decode.sv | 163 ++++++++++++++++
 tb/tb_decode.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : decode_pkg                                            |
// | Brief    : Shared opcodes, instruction field positions, default  |
// |            widths and the decoded control bundle for decode.     |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package decode_pkg;

  localparam int N_DEF  = 32;
  localparam int VW_DEF = 128;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADDI = 3'b001,
    OP_XOR  = 3'b010,
    OP_LDR  = 3'b011,
    OP_STR  = 3'b100,
    OP_B    = 3'b101,
    OP_AES  = 3'b110,
    OP_NOP  = 3'b111
  } opcode_e;

  // Instruction field positions
  localparam int OPC_HI = 23;
  localparam int OPC_LO = 21;
  localparam int V_BIT  = 20;
  localparam int RD_HI  = 19;
  localparam int RD_LO  = 16;
  localparam int RN_HI  = 15;
  localparam int RN_LO  = 12;
  localparam int RM_HI  = 3;
  localparam int RM_LO  = 0;
  localparam int IMM_HI = 11;
  localparam int BOFF_HI = 15;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic [2:0] alu_control;
    logic       ve;
  } ctrl_t;

  // Map opcode + vector flag to controls; anything illegal collapses to all-zero.
  function automatic ctrl_t decode_ctrl(input logic [2:0] op, input logic v,
                                        input logic vec_en);
    ctrl_t c;
    logic  legal;
    c = '0;
    if (v) legal = vec_en && (op != OP_B) && (op != OP_NOP);
    else   legal = (op != OP_AES) && (op != OP_NOP);
    if (legal) begin
      c.reg_write   = op inside {OP_ADD, OP_ADDI, OP_XOR, OP_LDR, OP_AES};
      c.mem_write   = (op == OP_STR);
      c.mem_to_reg  = (op == OP_LDR);
      c.branch      = (op == OP_B);
      c.alu_src     = op inside {OP_ADDI, OP_LDR, OP_STR};
      c.alu_control = op;
      c.ve          = v;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : register_file                                         |
// | Brief    : Two-read / one-write register file with optional      |
// |            write-through. Addresses >= DEPTH read ext_rd and     |
// |            are never written (used for R15 = PC+8).              |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module register_file #(
  parameter int DEPTH         = 15,
  parameter int WIDTH         = 32,
  parameter int AW            = 4,
  parameter bit WRITE_THROUGH = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic [WIDTH-1:0] ext_rd,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
);

  localparam int           AWX     = AW + 1;
  localparam logic [AW:0]  DEPTH_X = AWX'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wa_ok, ra1_ok, ra2_ok;
  logic             hit1, hit2;

  assign wa_ok  = {1'b0, wa}  < DEPTH_X;
  assign ra1_ok = {1'b0, ra1} < DEPTH_X;
  assign ra2_ok = {1'b0, ra2} < DEPTH_X;

  generate
    if (WRITE_THROUGH) begin : g_wt
      assign hit1 = we && wa_ok && (wa == ra1);
      assign hit2 = we && wa_ok && (wa == ra2);
    end else begin : g_no_wt
      assign hit1 = 1'b0;
      assign hit2 = 1'b0;
    end
  endgenerate

  // Storage: reset clears every entry, otherwise write in-range addresses
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && wa_ok) begin
      mem[wa] <= wd;
    end
  end

  // Read ports: out-of-range address selects ext_rd, a same-cycle write bypasses storage
  always_comb begin
    rd1 = ext_rd;
    rd2 = ext_rd;
    if (ra1_ok) rd1 = hit1 ? wd : mem[ra1];
    if (ra2_ok) rd2 = hit2 ? wd : mem[ra2];
  end

endmodule
`default_nettype wire

// File: rtl/decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : decode                                                |
// | Brief    : Instruction decode stage: field extraction, control   |
// |            decode, scalar (and optional vector) register files   |
// |            and the decode/execute pipeline register.             |
// | Config   : VEC_RF_EN - adds the 8 x VW vector RF, vector ports   |
// |            and the AESOP instruction.                            |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module decode
  import decode_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  InstrD,
  input  logic [N-1:0]  PCPlus8D,
  input  logic          RegWriteW,
  input  logic [3:0]    WA3W,
  input  logic [N-1:0]  ResultW,
`ifdef VEC_RF_EN
  input  logic          VecWriteW,
  input  logic [2:0]    VWA3W,
  input  logic [VW-1:0] VResultW,
`endif
  input  logic          StallE,
  input  logic          FlushE,
  output logic [3:0]    RA1D,
  output logic [3:0]    RA2D,
  output logic [N-1:0]  RD1E,
  output logic [N-1:0]  RD2E,
`ifdef VEC_RF_EN
  output logic [VW-1:0] VRD1E,
  output logic [VW-1:0] VRD2E,
`endif
  output logic [N-1:0]  ExtImmE,
  output logic [3:0]    WA3E,
  output logic [2:0]    ALUControlE,
  output logic          VE,
  output logic          RegWriteE,
  output logic          MemWriteE,
  output logic          MemtoRegE,
  output logic          BranchE,
  output logic          ALUSrcE,
  output logic [N-1:0]  PCPlus8E
);

`ifdef VEC_RF_EN
  localparam logic VEC_EN = 1'b1;
`else
  localparam logic VEC_EN = 1'b0;
`endif

  logic [2:0]   op;
  logic         v;
  logic [3:0]   rd, rn, rm;
  logic [11:0]  imm12;
  logic [15:0]  boff;
  ctrl_t        ctrl_d, ctrl_e;
  logic [N-1:0] ext_imm_d;
  logic [N-1:0] rd1_d, rd2_d;

  assign op    = InstrD[OPC_HI:OPC_LO];
  assign v     = InstrD[V_BIT];
  assign rd    = InstrD[RD_HI:RD_LO];
  assign rn    = InstrD[RN_HI:RN_LO];
  assign rm    = InstrD[RM_HI:RM_LO];
  assign imm12 = InstrD[IMM_HI:0];
  assign boff  = InstrD[BOFF_HI:0];

  assign ctrl_d = decode_ctrl(op, v, VEC_EN);

  // Stores read their data register through the second port
  assign RA1D = rn;
  assign RA2D = (op == OP_STR) ? rd : rm;

  // Immediate: zero-extended imm12 for address/ALU forms, word-scaled signed branch offset
  always_comb begin
    ext_imm_d = '0;
    case (op)
      OP_ADDI, OP_LDR, OP_STR: ext_imm_d = {{(N-12){1'b0}}, imm12};
      OP_B:                    ext_imm_d = {{(N-18){boff[15]}}, boff, 2'b00};
      default:                 ext_imm_d = '0;
    endcase
  end

  register_file #(
    .DEPTH(15), .WIDTH(N), .AW(4), .WRITE_THROUGH(1'b1)
  ) u_srf (
    .clk   (clk),
    .rst   (rst),
    .we    (RegWriteW),
    .wa    (WA3W),
    .wd    (ResultW),
    .ra1   (RA1D),
    .ra2   (RA2D),
    .ext_rd(PCPlus8D),
    .rd1   (rd1_d),
    .rd2   (rd2_d)
  );

`ifdef VEC_RF_EN
  logic [VW-1:0] vrd1_d, vrd2_d;

  register_file #(
    .DEPTH(8), .WIDTH(VW), .AW(3), .WRITE_THROUGH(1'b1)
  ) u_vrf (
    .clk   (clk),
    .rst   (rst),
    .we    (VecWriteW),
    .wa    (VWA3W),
    .wd    (VResultW),
    .ra1   (rn[2:0]),
    .ra2   (rm[2:0]),
    .ext_rd('0),
    .rd1   (vrd1_d),
    .rd2   (vrd2_d)
  );

  // Vector half of the decode/execute register: reset, flush, stall, capture
  always_ff @(posedge clk) begin
    if (!rst || FlushE) begin
      VRD1E <= '0;
      VRD2E <= '0;
    end else if (!StallE) begin
      VRD1E <= vrd1_d;
      VRD2E <= vrd2_d;
    end
  end
`endif

  // Scalar decode/execute register: reset, flush, stall, capture
  always_ff @(posedge clk) begin
    if (!rst || FlushE) begin
      RD1E     <= '0;
      RD2E     <= '0;
      ExtImmE  <= '0;
      WA3E     <= '0;
      ctrl_e   <= '0;
      PCPlus8E <= '0;
    end else if (!StallE) begin
      RD1E     <= rd1_d;
      RD2E     <= rd2_d;
      ExtImmE  <= ext_imm_d;
      WA3E     <= rd;
      ctrl_e   <= ctrl_d;
      PCPlus8E <= PCPlus8D;
    end
  end

  assign RegWriteE   = ctrl_e.reg_write;
  assign MemWriteE   = ctrl_e.mem_write;
  assign MemtoRegE   = ctrl_e.mem_to_reg;
  assign BranchE     = ctrl_e.branch;
  assign ALUSrcE     = ctrl_e.alu_src;
  assign ALUControlE = ctrl_e.alu_control;
  assign VE          = ctrl_e.ve;

endmodule
`default_nettype wire

// File: tb/tb_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_decode                                             |
// | Brief    : Directed self-checking bench for decode. Build with   |
// |            or without VEC_RF_EN.                                 |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_decode;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   InstrD, PCPlus8D, ResultW;
  logic          RegWriteW;
  logic [3:0]    WA3W;
  logic          StallE, FlushE;
  logic [3:0]    RA1D, RA2D;
  logic [31:0]   RD1E, RD2E, ExtImmE, PCPlus8E;
  logic [3:0]    WA3E;
  logic [2:0]    ALUControlE;
  logic          VE, RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE;
`ifdef VEC_RF_EN
  logic          VecWriteW;
  logic [2:0]    VWA3W;
  logic [127:0]  VResultW, VRD1E, VRD2E;
`endif

  int compared   = 0;
  int mismatched = 0;

  // {RegWrite, MemWrite, MemtoReg, Branch, ALUSrc, ALUControl[2:0], VE}
  logic [8:0] e_ctrl;
  assign e_ctrl = {RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE, ALUControlE, VE};

  localparam logic [8:0] C_ADDI = 9'b1_0_0_0_1_001_0;
  localparam logic [8:0] C_ADD  = 9'b1_0_0_0_0_000_0;
  localparam logic [8:0] C_XOR  = 9'b1_0_0_0_0_010_0;
  localparam logic [8:0] C_LDR  = 9'b1_0_1_0_1_011_0;
  localparam logic [8:0] C_STR  = 9'b0_1_0_0_1_100_0;
  localparam logic [8:0] C_B    = 9'b0_0_0_1_0_101_0;
  localparam logic [8:0] C_VAES = 9'b1_0_0_0_0_110_1;
  localparam logic [8:0] C_VADD = 9'b1_0_0_0_0_000_1;

  decode #(.N(32), .VW(128)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCPlus8D(PCPlus8D),
    .RegWriteW(RegWriteW), .WA3W(WA3W), .ResultW(ResultW),
`ifdef VEC_RF_EN
    .VecWriteW(VecWriteW), .VWA3W(VWA3W), .VResultW(VResultW),
`endif
    .StallE(StallE), .FlushE(FlushE), .RA1D(RA1D), .RA2D(RA2D),
    .RD1E(RD1E), .RD2E(RD2E),
`ifdef VEC_RF_EN
    .VRD1E(VRD1E), .VRD2E(VRD2E),
`endif
    .ExtImmE(ExtImmE), .WA3E(WA3E), .ALUControlE(ALUControlE), .VE(VE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .PCPlus8E(PCPlus8E)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; InstrD = 32'h0021_0005; PCPlus8D = 32'h0000_0100;
    step(); step();
    compared++; if (e_ctrl !== 9'h0) begin mismatched++; $display("FAIL reset_ctrl: got %h want 000", e_ctrl); end
    compared++; if ({RD1E, RD2E, ExtImmE, PCPlus8E, WA3E} !== '0) begin mismatched++;
      $display("FAIL reset_data: got %h %h %h %h %h want all 0", RD1E, RD2E, ExtImmE, PCPlus8E, WA3E); end
  endtask

  task automatic test_addi();
    rst = 1'b1; InstrD = 32'h0021_0005; PCPlus8D = 32'h0000_0100;
    #1;
    compared++; if (RA1D !== 4'd0 || RA2D !== 4'd5) begin mismatched++;
      $display("FAIL addi_ra: got %h/%h want 0/5", RA1D, RA2D); end
    step();
    compared++; if (e_ctrl !== C_ADDI) begin mismatched++; $display("FAIL addi_ctrl: got %h want %h", e_ctrl, C_ADDI); end
    compared++; if (ExtImmE !== 32'd5 || WA3E !== 4'd1 || RD1E !== 32'd0 || PCPlus8E !== 32'h100) begin mismatched++;
      $display("FAIL addi_data: got imm=%h wa=%h rd1=%h pc8=%h want 5/1/0/100", ExtImmE, WA3E, RD1E, PCPlus8E); end
  endtask

  task automatic test_stall_flush();
    StallE = 1'b1; InstrD = 32'h0047_8009; PCPlus8D = 32'h0000_0200;
    for (int i = 0; i < 2; i++) begin
      step();
      compared++; if (e_ctrl !== C_ADDI || ExtImmE !== 32'd5 || WA3E !== 4'd1 || PCPlus8E !== 32'h100) begin mismatched++;
        $display("FAIL stall_hold%0d: got ctrl=%h imm=%h wa=%h pc8=%h want %h/5/1/100", i, e_ctrl, ExtImmE, WA3E, PCPlus8E, C_ADDI); end
    end
    FlushE = 1'b1;
    step();
    compared++; if (e_ctrl !== 9'h0 || {RD1E, RD2E, ExtImmE, PCPlus8E, WA3E} !== '0) begin mismatched++;
      $display("FAIL flush_over_stall: got ctrl=%h imm=%h wa=%h pc8=%h want all 0", e_ctrl, ExtImmE, WA3E, PCPlus8E); end
    FlushE = 1'b0; StallE = 1'b0;
    step();
    compared++; if (e_ctrl !== C_XOR || WA3E !== 4'd7 || ExtImmE !== 32'd0 || PCPlus8E !== 32'h200) begin mismatched++;
      $display("FAIL resume_xor: got ctrl=%h wa=%h imm=%h pc8=%h want %h/7/0/200", e_ctrl, WA3E, ExtImmE, PCPlus8E, C_XOR); end
  endtask

  task automatic test_writethrough();
    RegWriteW = 1'b1; WA3W = 4'd4; ResultW = 32'h0000_1234; InstrD = 32'h00E0_0000;
    step();
    compared++; if (e_ctrl !== 9'h0) begin mismatched++; $display("FAIL nop_ctrl: got %h want 000", e_ctrl); end
    WA3W = 4'd3; ResultW = 32'hDEAD_BEEF; InstrD = 32'h0002_3004;
    step();
    compared++; if (RD1E !== 32'hDEAD_BEEF || RD2E !== 32'h0000_1234 || e_ctrl !== C_ADD) begin mismatched++;
      $display("FAIL wt_add: got rd1=%h rd2=%h ctrl=%h want deadbeef/1234/%h", RD1E, RD2E, e_ctrl, C_ADD); end
    RegWriteW = 1'b0;
    step();
    compared++; if (RD1E !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL rf_stored: got %h want deadbeef", RD1E); end
  endtask

  task automatic test_r15_branch();
    RegWriteW = 1'b1; WA3W = 4'd15; ResultW = 32'hAAAA_AAAA;
    InstrD = 32'h00A0_FFFF; PCPlus8D = 32'h0000_0010;
    #1;
    compared++; if (RA1D !== 4'd15) begin mismatched++; $display("FAIL b_ra1: got %h want f", RA1D); end
    step();
    RegWriteW = 1'b0;
    compared++; if (ExtImmE !== 32'hFFFF_FFFC || e_ctrl !== C_B) begin mismatched++;
      $display("FAIL b_imm: got imm=%h ctrl=%h want fffffffc/%h", ExtImmE, e_ctrl, C_B); end
    compared++; if (RD1E !== 32'h10 || RD2E !== 32'h10) begin mismatched++;
      $display("FAIL r15_read: got %h/%h want 10/10", RD1E, RD2E); end
  endtask

  task automatic test_mem_ops();
    InstrD = 32'h0085_1034;
    #1;
    compared++; if (RA1D !== 4'd1 || RA2D !== 4'd5) begin mismatched++;
      $display("FAIL str_ra: got %h/%h want 1/5", RA1D, RA2D); end
    step();
    compared++; if (e_ctrl !== C_STR || ExtImmE !== 32'h34 || WA3E !== 4'd5) begin mismatched++;
      $display("FAIL str_e: got ctrl=%h imm=%h wa=%h want %h/34/5", e_ctrl, ExtImmE, WA3E, C_STR); end
    InstrD = 32'h0066_3010;
    step();
    compared++; if (e_ctrl !== C_LDR || ExtImmE !== 32'h10 || RD1E !== 32'hDEAD_BEEF || WA3E !== 4'd6) begin mismatched++;
      $display("FAIL ldr_e: got ctrl=%h imm=%h rd1=%h wa=%h want %h/10/deadbeef/6", e_ctrl, ExtImmE, RD1E, WA3E, C_LDR); end
  endtask

  task automatic test_vector_ops();
    logic [127:0] pat;
    pat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    InstrD = 32'h00D1_2003;
`ifdef VEC_RF_EN
    VecWriteW = 1'b1; VWA3W = 3'd2; VResultW = pat;
`endif
    step();
`ifdef VEC_RF_EN
    VecWriteW = 1'b0;
    compared++; if (e_ctrl !== C_VAES) begin mismatched++; $display("FAIL aes_ctrl: got %h want %h", e_ctrl, C_VAES); end
    compared++; if (VRD1E !== pat || VRD2E !== 128'h0) begin mismatched++;
      $display("FAIL aes_vrd: got %h/%h want %h/0", VRD1E, VRD2E, pat); end
`else
    compared++; if (e_ctrl !== 9'h0) begin mismatched++; $display("FAIL aes_ctrl: got %h want 000", e_ctrl); end
    if (pat === 128'h0) $display("unexpected pattern");
`endif
    InstrD = 32'h00C1_2003;
    step();
    compared++; if (e_ctrl !== 9'h0) begin mismatched++; $display("FAIL aes_v0_nop: got %h want 000", e_ctrl); end
    InstrD = 32'h0013_2003;
    step();
`ifdef VEC_RF_EN
    compared++; if (e_ctrl !== C_VADD) begin mismatched++; $display("FAIL vadd_ctrl: got %h want %h", e_ctrl, C_VADD); end
`else
    compared++; if (e_ctrl !== 9'h0) begin mismatched++; $display("FAIL vadd_nop: got %h want 000", e_ctrl); end
`endif
    InstrD = 32'h00B0_0000;
    step();
    compared++; if (e_ctrl !== 9'h0) begin mismatched++; $display("FAIL vb_nop: got %h want 000", e_ctrl); end
  endtask

  task automatic test_reset_stall();
    RegWriteW = 1'b1; WA3W = 4'd1; ResultW = 32'h0000_0055; InstrD = 32'h0021_0005;
    step();
    RegWriteW = 1'b0; InstrD = 32'h0002_1000; PCPlus8D = 32'h0000_0300;
    step();
    compared++; if (RD1E !== 32'h55 || e_ctrl !== C_ADD) begin mismatched++;
      $display("FAIL r1_before_rst: got rd1=%h ctrl=%h want 55/%h", RD1E, e_ctrl, C_ADD); end
    StallE = 1'b1; rst = 1'b0;
    step();
    compared++; if (e_ctrl !== 9'h0 || {RD1E, RD2E, ExtImmE, PCPlus8E, WA3E} !== '0) begin mismatched++;
      $display("FAIL rst_over_stall: got ctrl=%h rd1=%h pc8=%h wa=%h want all 0", e_ctrl, RD1E, PCPlus8E, WA3E); end
    rst = 1'b1; StallE = 1'b0;
    step();
    compared++; if (RD1E !== 32'h0 || e_ctrl !== C_ADD || PCPlus8E !== 32'h300) begin mismatched++;
      $display("FAIL r1_after_rst: got rd1=%h ctrl=%h pc8=%h want 0/%h/300", RD1E, e_ctrl, PCPlus8E, C_ADD); end
  endtask

  initial begin
    rst = 1'b0; InstrD = '0; PCPlus8D = '0; RegWriteW = 1'b0; WA3W = '0; ResultW = '0;
    StallE = 1'b0; FlushE = 1'b0;
`ifdef VEC_RF_EN
    VecWriteW = 1'b0; VWA3W = '0; VResultW = '0;
`endif
    test_reset();
    test_addi();
    test_stall_flush();
    test_writethrough();
    test_r15_branch();
    test_mem_ops();
    test_vector_ops();
    test_reset_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
